tpu_tile_sched: RTL and testbench

- Sequencing controller for the TPU systolic datapath.
- Splits an m x k by k x n matmul into ARR x ARR output tiles.
- Streams A and B operand words from the GBUFF_A and GBUFF_B SRAMs into the TPU, and writes tile results into GBUFF_OUT.
- Replaces the single-tile hard-wired control FSM in the top level, so dimensions above the array size are handled.

---
 rtl/tpu_tile_sched_pkg.sv | 22 ++
 rtl/tpu_tile_sched_tile_addr_gen.sv | 91 +++++++++
 rtl/tpu_tile_sched.sv | 99 +++++++++
 tb/tb_tpu_tile_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_tile_sched_pkg.sv
// Shared types and helpers for the TPU tile scheduler: FSM encoding, word address width, tile counts.
// No timing of its own; everything here is constants or pure functions.
package tpu_tile_sched_pkg;

  localparam int WORD_ADDR_BITS = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FEED  = 3'd2,
    LAST  = 3'd3,
    DRAIN = 3'd4,
    NEXT  = 3'd5,
    FIN   = 3'd6
  } state_t;

  // Ceil-divide a dimension by the array edge; 9 bits so that 255 rounds up to 64 rather than wrapping.
  function automatic logic [8:0] tile_count(input logic [7:0] dim, input int arr, input int lg2);
    return (9'(dim) + 9'(arr - 1)) >> lg2;
  endfunction

endpackage

// File: rtl/tpu_tile_sched_tile_addr_gen.sv
// Tile/step/beat counters and the GBUFF A/B/OUT address arithmetic for the tile scheduler.
// Addresses are combinational from registered counters; no backpressure, steps advance only when the FSM says so.
module tile_addr_gen
  import tpu_tile_sched_pkg::*;
#(
  parameter int ARR      = 4,
  parameter int ARR_LG2  = 2,
  parameter int ADDR_W   = WORD_ADDR_BITS,
  parameter int A_BASE   = 0,
  parameter int B_BASE   = 0,
  parameter int OUT_BASE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [7:0]        m,
  input  logic [7:0]        k,
  input  logic [7:0]        n,
  input  logic              feed,
  input  logic              drain_beat,
  input  logic              next_tile,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              kk_last,
  output logic              r_last,
  output logic              tile_last
);

  logic [7:0]                k_q;
  logic [8:0]                mt_q;
  logic [8:0]                nt_q;
  logic [8:0]                ti;
  logic [8:0]                tj;
  logic [7:0]                kk;
  logic [ARR_LG2-1:0]        r;
  logic [ADDR_W-1:0]         a_row;
  logic [ADDR_W-1:0]         b_col;
  logic [ADDR_W-ARR_LG2-1:0] tile_idx;
  logic [ADDR_W-1:0]         k_ext;

  assign k_ext = ADDR_W'(k_q);

  // Row/column bases advance by k per tile step, so ti*k and tj*k never need a multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q      <= '0;
      mt_q     <= '0;
      nt_q     <= '0;
      ti       <= '0;
      tj       <= '0;
      kk       <= '0;
      r        <= '0;
      a_row    <= '0;
      b_col    <= '0;
      tile_idx <= '0;
    end else begin
      kk <= feed ? kk + 8'd1 : 8'd0;
      if (drain_beat) r <= r + 1'b1;
      if (load) begin
        k_q      <= k;
        mt_q     <= tile_count(m, ARR, ARR_LG2);
        nt_q     <= tile_count(n, ARR, ARR_LG2);
        ti       <= '0;
        tj       <= '0;
        a_row    <= '0;
        b_col    <= '0;
        tile_idx <= '0;
      end else if (next_tile) begin
        tile_idx <= tile_idx + 1'b1;
        if (tj == nt_q - 9'd1) begin
          tj    <= '0;
          b_col <= '0;
          ti    <= ti + 9'd1;
          a_row <= a_row + k_ext;
        end else begin
          tj    <= tj + 9'd1;
          b_col <= b_col + k_ext;
        end
      end
    end
  end

  assign a_addr    = ADDR_W'(A_BASE) + a_row + ADDR_W'(kk);
  assign b_addr    = ADDR_W'(B_BASE) + b_col + ADDR_W'(kk);
  assign out_addr  = ADDR_W'(OUT_BASE) + {tile_idx, r};
  assign kk_last   = (kk == k_q - 8'd1);
  assign r_last    = &r;
  assign tile_last = (ti == mt_q - 9'd1) && (tj == nt_q - 9'd1);

endmodule

// File: rtl/tpu_tile_sched.sv
// Tiles an m x k by k x n matmul into ARR x ARR output tiles, sequencing SRAM reads, TPU clears and result writes.
// Per tile: 1 clear + k feed + 1 last cycle, then waits as long as needed for ARR tpu_out_valid beats.
module tpu_tile_sched
  import tpu_tile_sched_pkg::*;
#(
  parameter int ARR      = 4,
  parameter int ARR_LG2  = 2,
  parameter int ADDR_W   = WORD_ADDR_BITS,
  parameter int A_BASE   = 0,
  parameter int B_BASE   = 0,
  parameter int OUT_BASE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        m,
  input  logic [7:0]        k,
  input  logic [7:0]        n,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              tpu_clear,
  output logic              tpu_in_valid,
  input  logic              tpu_out_valid,
  output logic              out_wen,
  output logic [ADDR_W-1:0] out_addr
);

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   cfg_zero;
  logic   kk_last;
  logic   r_last;
  logic   tile_last;

  assign accept   = (state == IDLE) && start;
  assign cfg_zero = (m == 8'd0) || (k == 8'd0) || (n == 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tpu_in_valid <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      // SRAM read latency is one cycle, so valid trails the address by one.
      tpu_in_valid <= (state == FEED);
      if (accept) cfg_err <= cfg_zero;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = cfg_zero ? FIN : CLR;
      CLR:     state_nxt = FEED;
      FEED:    if (kk_last) state_nxt = LAST;
      LAST:    state_nxt = DRAIN;
      DRAIN:   if (tpu_out_valid && r_last) state_nxt = NEXT;
      NEXT:    state_nxt = tile_last ? FIN : CLR;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE) && (state != FIN);
  assign done      = (state == FIN);
  assign tpu_clear = (state == CLR);
  assign out_wen   = (state == DRAIN) && tpu_out_valid;

  tile_addr_gen #(
    .ARR      (ARR),
    .ARR_LG2  (ARR_LG2),
    .ADDR_W   (ADDR_W),
    .A_BASE   (A_BASE),
    .B_BASE   (B_BASE),
    .OUT_BASE (OUT_BASE)
  ) u_addr (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .m          (m),
    .k          (k),
    .n          (n),
    .feed       (state == FEED),
    .drain_beat (out_wen),
    .next_tile  (state == NEXT),
    .a_addr     (a_addr),
    .b_addr     (b_addr),
    .out_addr   (out_addr),
    .kk_last    (kk_last),
    .r_last     (r_last),
    .tile_last  (tile_last)
  );

endmodule

// File: tb/tb_tpu_tile_sched.sv
// Scoreboard bench for tpu_tile_sched: stimulus queues expected addresses, a negedge monitor pops and compares.
// A behavioural TPU answers each tile with ARR result beats (with a gap) and one stray beat outside DRAIN.
module tb_tpu_tile_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] m = 8'd0;
  logic [7:0] k = 8'd0;
  logic [7:0] n = 8'd0;
  logic       tpu_out_valid = 1'b0;
  logic       busy, done, cfg_err, tpu_clear, tpu_in_valid, out_wen;
  logic [9:0] a_addr, b_addr, out_addr;

  tpu_tile_sched dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .m             (m),
    .k             (k),
    .n             (n),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err),
    .a_addr        (a_addr),
    .b_addr        (b_addr),
    .tpu_clear     (tpu_clear),
    .tpu_in_valid  (tpu_in_valid),
    .tpu_out_valid (tpu_out_valid),
    .out_wen       (out_wen),
    .out_addr      (out_addr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_a[$];
  int exp_b[$];
  int exp_out[$];
  int exp_err[$];
  int n_clear = 0;
  int n_iv = 0;
  int pa = 0;
  int pb = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: addresses seen on a valid beat are those presented one cycle earlier.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_wen) begin
          if (exp_out.size() == 0) chk("out_wen_without_expect", int'(out_wen), 0);
          else chk("out_addr", int'(out_addr), exp_out.pop_front());
        end
        if (tpu_in_valid) begin
          n_iv++;
          if (exp_a.size() == 0) chk("in_valid_without_expect", int'(tpu_in_valid), 0);
          else begin
            chk("a_addr", pa, exp_a.pop_front());
            chk("b_addr", pb, exp_b.pop_front());
          end
        end
        if (done) begin
          if (exp_err.size() == 0) chk("done_without_expect", int'(done), 0);
          else chk("cfg_err_at_done", int'(cfg_err), exp_err.pop_front());
        end
        if (tpu_clear) n_clear++;
      end
      pa = int'(a_addr);
      pb = int'(b_addr);
    end
  end

  // TPU model: stray beat during CLR, then after the last operand beat: 1,1,0,1,1.
  initial begin
    bit prev_iv;
    prev_iv = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tpu_clear) begin
        tpu_out_valid = 1'b1;
        @(posedge clk); #1;
        tpu_out_valid = 1'b0;
      end else if (prev_iv && !tpu_in_valid) begin
        for (int i = 0; i < 5; i++) begin
          tpu_out_valid = (i != 2);
          @(posedge clk); #1;
        end
        tpu_out_valid = 1'b0;
      end
      prev_iv = tpu_in_valid;
    end
  end

  task automatic push_job(input int mm, input int kk_n, input int nn);
    int mt, nt;
    mt = (mm + 3) / 4;
    nt = (nn + 3) / 4;
    for (int ti = 0; ti < mt; ti++)
      for (int tj = 0; tj < nt; tj++) begin
        for (int s = 0; s < kk_n; s++) begin
          exp_a.push_back((ti * kk_n + s) % 1024);
          exp_b.push_back((tj * kk_n + s) % 1024);
        end
        for (int r = 0; r < 4; r++) exp_out.push_back(((ti * nt + tj) * 4 + r) % 1024);
      end
    exp_err.push_back(0);
  endtask

  // Config is zeroed right after the accepting edge; a resampling design would misbehave.
  task automatic pulse_start(input int mm, input int kk_n, input int nn);
    @(posedge clk); #1;
    m = 8'(mm); k = 8'(kk_n); n = 8'(nn); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; m = 8'd0; k = 8'd0; n = 8'd0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_cfg_err"}, int'(cfg_err), 0);
    chk({tag, "_tpu_clear"}, int'(tpu_clear), 0);
    chk({tag, "_in_valid"}, int'(tpu_in_valid), 0);
    chk({tag, "_out_wen"}, int'(out_wen), 0);
    chk({tag, "_a_addr"}, int'(a_addr), 0);
    chk({tag, "_b_addr"}, int'(b_addr), 0);
    chk({tag, "_out_addr"}, int'(out_addr), 0);
  endtask

  task automatic run_job(input int mm, input int kk_n, input int nn, input int tiles, input int beats, input bit poke);
    int c0, v0;
    bit seen;
    push_job(mm, kk_n, nn);
    c0 = n_clear;
    v0 = n_iv;
    pulse_start(mm, kk_n, nn);
    @(negedge clk);
    chk("busy_after_start", int'(busy), 1);
    chk("cfg_err_cleared", int'(cfg_err), 0);
    if (poke) begin
      @(posedge clk); #1;
      start = 1'b1; m = 8'd8; k = 8'd8; n = 8'd8;
      @(posedge clk); #1;
      start = 1'b0; m = 8'd0; k = 8'd0; n = 8'd0;
    end
    wait_done(seen);
    chk("done_seen", int'(seen), 1);
    chk("busy_at_done", int'(busy), 0);
    chk("tile_clears", n_clear - c0, tiles);
    chk("in_valid_beats", n_iv - v0, beats);
    chk("out_queue_left", exp_out.size(), 0);
    chk("ab_queue_left", exp_a.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    if (poke) begin
      repeat (4) @(negedge clk);
      chk("no_restart_busy", int'(busy), 0);
    end
  endtask

  initial begin
    bit seen;
    int v0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    #2 rst = 1'b0;

    run_job(4, 4, 4, 1, 4, 1'b0);
    run_job(8, 3, 8, 4, 12, 1'b0);
    run_job(5, 2, 4, 2, 4, 1'b0);
    run_job(255, 1, 1, 64, 64, 1'b0);

    // Zero dimension: immediate done with cfg_err, no datapath activity.
    exp_err.push_back(1);
    v0 = n_iv;
    pulse_start(4, 0, 4);
    @(negedge clk);
    chk("err_done", int'(done), 1);
    chk("err_cfg_err", int'(cfg_err), 1);
    chk("err_busy", int'(busy), 0);
    @(negedge clk);
    chk("err_done_one_cycle", int'(done), 0);
    chk("err_cfg_err_held", int'(cfg_err), 1);
    chk("err_no_in_valid", n_iv - v0, 0);

    // Valid start after the error clears cfg_err; a start during FEED is ignored.
    run_job(4, 4, 4, 1, 4, 1'b1);

    // Reset in the middle of DRAIN abandons the job.
    push_job(4, 4, 4);
    pulse_start(4, 4, 4);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (out_wen) seen = 1'b1;
    end
    chk("reached_drain", int'(seen), 1);
    #2 rst = 1'b1;
    #1 check_zero("mid_rst");
    exp_a.delete();
    exp_b.delete();
    exp_out.delete();
    exp_err.delete();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);
    run_job(4, 4, 4, 1, 4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
